// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and backing-memory signal bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_i;
  logic              we0_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [DATA_W-1:0] wdata0_i;
  logic              req1_i;
  logic              we1_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata1_i;
  logic              ack0_o;
  logic              ack1_o;
  logic [DATA_W-1:0] rdata_o;
  logic              err_o;
  logic              busy_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  req0_i, we0_i, addr0_i, wdata0_i,
    input  req1_i, we1_i, addr1_i, wdata1_i,
    output ack0_o, ack1_o, rdata_o, err_o, busy_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport master (
    output req0_i, we0_i, addr0_i, wdata0_i,
    output req1_i, we1_i, addr1_i, wdata1_i,
    input  ack0_o, ack1_o, rdata_o, err_o, busy_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one multi-cycle memory port between two requesters
// All outputs are registered; the output process computes their next values.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_grant;
  logic              last_grant_nxt;
  logic              grant;
  logic              grant_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;

  logic              ack0_q;
  logic              ack0_nxt;
  logic              ack1_q;
  logic              ack1_nxt;
  logic              err_q;
  logic              err_nxt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_nxt;
  logic              busy_q;
  logic              busy_nxt;
  logic              mem_en_q;
  logic              mem_en_nxt;
  logic              mem_we_q;
  logic              mem_we_nxt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] mem_wdata_nxt;

  logic              any_req;
  logic              sel;
  logic              timeout_hit;

  assign any_req     = bus.req0_i | bus.req1_i;
  // On a tie the port that was not served last wins; otherwise the sole requester.
  assign sel         = (bus.req0_i & bus.req1_i) ? ~last_grant : bus.req1_i;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      cnt         <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      grant       <= grant_nxt;
      cnt         <= cnt_nxt;
      ack0_q      <= ack0_nxt;
      ack1_q      <= ack1_nxt;
      err_q       <= err_nxt;
      rdata_q     <= rdata_nxt;
      busy_q      <= busy_nxt;
      mem_en_q    <= mem_en_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (bus.mem_ack_i || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    cnt_nxt        = cnt;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    err_nxt        = 1'b0;
    rdata_nxt      = '0;
    mem_en_nxt     = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = '0;
    mem_wdata_nxt  = '0;
    busy_nxt       = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_nxt      = sel;
          last_grant_nxt = sel;
          cnt_nxt        = '0;
          mem_en_nxt     = 1'b1;
          mem_we_nxt     = sel ? bus.we1_i    : bus.we0_i;
          mem_addr_nxt   = sel ? bus.addr1_i  : bus.addr0_i;
          mem_wdata_nxt  = sel ? bus.wdata1_i : bus.wdata0_i;
        end
      end
      BUSY: begin
        // A memory ack in the final wait cycle still counts as a normal completion.
        if (bus.mem_ack_i) begin
          ack0_nxt  = ~grant;
          ack1_nxt  = grant;
          rdata_nxt = mem_we_q ? '0 : bus.mem_rdata_i;
        end else if (timeout_hit) begin
          ack0_nxt = ~grant;
          ack1_nxt = grant;
          err_nxt  = 1'b1;
        end else begin
          cnt_nxt       = cnt + CNT_W'(1);
          mem_en_nxt    = mem_en_q;
          mem_we_nxt    = mem_we_q;
          mem_addr_nxt  = mem_addr_q;
          mem_wdata_nxt = mem_wdata_q;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.ack0_o       = ack0_q;
  assign bus.ack1_o       = ack1_q;
  assign bus.err_o        = err_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.busy_o       = busy_q;
  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_write_o  = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one multi-cycle backing data memory port between two requesters: port 0 (MEM-stage load/store) and port 1 (instruction fetch).
- Fair round-robin arbitration, registered memory-side handshake, per-transaction acknowledge and a watchdog timeout.
- Sits between the pipeline's memory-access units and the word-wide data memory.
- Pipeline stall logic is driven from busy_o and the ack outputs.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.
- TIMEOUT, 16, maximum BUSY cycles spent waiting for mem_ack_i before abort; legal range 2..255.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req0_i  in  1  port 0 request; held high until ack0_o is seen.
- we0_i  in  1  port 0 write (1) / read (0).
- addr0_i  in  ADDR_W  port 0 byte address.
- wdata0_i  in  DATA_W  port 0 write data.
- req1_i, we1_i, addr1_i, wdata1_i  in  1/1/ADDR_W/DATA_W  port 1, same meaning as port 0.
- ack0_o  out  1  one-cycle completion pulse to port 0.
- ack1_o  out  1  one-cycle completion pulse to port 1.
- rdata_o  out  DATA_W  read data, valid only while ack0_o or ack1_o is high.
- err_o  out  1  timeout flag; pulses together with the ack of the aborted transaction.
- busy_o  out  1  high in BUSY and DONE.
- mem_enable_o  out  1  request to the backing memory.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_ack_i  in  1  memory completion; single-cycle pulse.
- mem_rdata_i  in  DATA_W  memory read data, valid while mem_ack_i is high.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE, last_grant = 1, wait counter = 0.
  - All outputs 0; mem_enable_o drops without waiting for a clock edge.
  - An in-flight transaction is discarded and no ack is issued.
- All outputs are registered. There is no combinational path from any input to any output.
- FSM: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - Samples req0_i and req1_i.
  - Only one request high: grant that port.
  - Both high: grant the port that is not last_grant, so port 0 wins the first tie after reset.
  - On grant, at the edge: latch we, addr and wdata into the mem_* outputs, set mem_enable_o = 1, update last_grant, clear the counter, go to BUSY.
  - No request: stay in IDLE.
- BUSY:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_wdata_o are held constant.
  - mem_ack_i = 1: capture mem_rdata_i into rdata_o (write transactions capture 0), go to DONE.
  - mem_ack_i = 0 and counter == TIMEOUT-1: go to DONE with rdata_o = 0 and err_o = 1.
  - Otherwise increment the counter.
  - mem_ack_i takes priority over timeout when both occur in the same cycle, so err_o = 0.
- DONE:
  - Exactly one of ack0_o/ack1_o is high, matching the granted port; mem_* outputs are 0.
  - Next state is always IDLE.
  - Requests are not sampled in DONE. A requester drops req at the edge that ends DONE, so it is not served twice.
- Minimum latency: request seen in IDLE at cycle N, mem_ack_i at N+1, ack at N+2.
- Latency with a memory ack k cycles after enable (k ≥ 1): ack at N+1+k.
- Latency on timeout: ack plus err at N+1+TIMEOUT.
- Outside DONE: ack0_o, ack1_o, err_o and rdata_o are 0.
- busy_o = (state != IDLE).
- mem_ack_i while not in BUSY is ignored.
- A change in the requester's addr or wdata during BUSY is ignored, because the values were latched at grant.
- The counter is wide enough to hold TIMEOUT-1 and never wraps.

Test Plan:
- Reset: assert rst_i with no clock running → every output 0 immediately. Release it, hold both requests low for 5 cycles → state stays IDLE, busy_o = 0.
- Port 0 read: addr0 = 0x10, memory acks 3 cycles after enable with 0xDEADBEEF.
  - mem_enable_o high for 3 cycles, mem_addr_o = 0x10, mem_write_o = 0.
  - ack0_o pulses one cycle with rdata_o = 0xDEADBEEF; ack1_o and err_o stay 0.
- Port 1 write: addr1 = 0x1C, wdata1 = 0x12345678, memory acks after 1 cycle → mem_write_o = 1 with that address and data, ack1_o pulse with rdata_o = 0.
- Arbitration: after reset, both ports hold requests for 4 transactions → grant order 0, 1, 0, 1. With only req1 high, repeated port 1 grants are allowed.
- Timeout: TIMEOUT = 8, memory never acks → mem_enable_o high for exactly 8 cycles, then ack0_o and err_o pulse together with rdata_o = 0. The next transaction completes normally with err_o = 0.
- Reset mid-BUSY: assert rst_i on the 2nd BUSY cycle → mem_enable_o drops without waiting for a clock edge and no ack is issued. After release, the first tie is granted to port 0.
